// File: rtl/game_pkg.sv
// Shared FSM state type and default playfield geometry for the ball engine.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    MOVE,
    SEND,
    WAIT_RX,
    OVER
  } state_t;

  localparam int DEFAULT_H_RES     = 640;
  localparam int DEFAULT_V_RES     = 480;
  localparam int DEFAULT_BALL_SIZE = 20;

endpackage

// File: rtl/ball_vertical_phys.sv
// Combinational per-frame vertical step: y += vy with wall bounce, then gravity.
module ball_vertical_phys
  import game_pkg::*;
#(
  parameter int V_RES       = DEFAULT_V_RES,
  parameter int BALL_SIZE   = DEFAULT_BALL_SIZE,
  parameter int GRAV_PERIOD = 4
) (
  input  logic              [9:0] y,
  input  logic signed       [7:0] vy,
  input  logic              [1:0] grav_cnt,
  output logic              [9:0] y_next,
  output logic signed       [7:0] vy_next,
  output logic              [1:0] grav_cnt_next
);

  localparam logic signed [10:0] Y_MAX     = 11'(V_RES - BALL_SIZE);
  localparam logic        [1:0]  GRAV_LAST = 2'(GRAV_PERIOD - 1);

  // Negating -128 cannot be represented; pin it to +127.
  function automatic logic signed [7:0] sat_neg(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh7f : -v;
  endfunction

  function automatic logic signed [7:0] sat_inc(input logic signed [7:0] v);
    return (v == 8'sh7f) ? v : v + 8'sd1;
  endfunction

  logic signed [10:0] y_sum;
  logic signed [7:0]  vy_bounce;

  always_comb begin
    y_sum     = $signed({1'b0, y}) + $signed({{3{vy[7]}}, vy});
    y_next    = y;
    vy_bounce = vy;
    if (y_sum < 11'sd0) begin
      y_next    = '0;
      vy_bounce = sat_neg(vy);
    end else if (y_sum > Y_MAX) begin
      y_next    = Y_MAX[9:0];
      vy_bounce = sat_neg(vy);
    end else begin
      y_next = y_sum[9:0];
    end

    if (grav_cnt == GRAV_LAST) begin
      grav_cnt_next = '0;
      vy_next       = sat_inc(vy_bounce);
    end else begin
      grav_cnt_next = grav_cnt + 2'd1;
      vy_next       = vy_bounce;
    end
  end

endmodule

// File: rtl/game_ball_engine.sv
// Ball engine: serve, horizontal motion, paddle hits, miss detection and
// hand-off of the ball to/from a remote board in versus mode.
module game_ball_engine
  import game_pkg::*;
#(
  parameter int H_RES        = DEFAULT_H_RES,
  parameter int V_RES        = DEFAULT_V_RES,
  parameter int BALL_SIZE    = DEFAULT_BALL_SIZE,
  parameter int INIT_SPEED   = 4,
  parameter int MAX_SPEED    = 16,
  parameter int GRAV_PERIOD  = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk_25MHZ,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       mode,
  input  logic       game_start,
  input  logic       collision_detected,
  input  logic [9:0] estimated_speed,
  input  logic       rx_valid,
  input  logic [9:0] rx_ball_y,
  input  logic [7:0] rx_vy,
  input  logic [7:0] rx_speed,
  output logic [9:0] ball_x_out,
  output logic [9:0] ball_y_out,
  output logic       is_ball_moving_left,
  output logic       game_over,
  output logic       ball_send_trigger,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic [7:0] ball_speed
);

  localparam int         SW       = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] X_CENTER = 10'(H_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0] Y_CENTER = 10'(V_RES / 2 - BALL_SIZE / 2);
  localparam logic [9:0] X_RIGHT  = 10'(H_RES - BALL_SIZE);
  localparam logic [9:0] X_OFF    = 10'(H_RES);
  localparam logic [9:0] Y_MAX    = 10'(V_RES - BALL_SIZE);
  localparam logic [7:0] INIT_SPD = 8'(INIT_SPEED);
  localparam logic [7:0] MAX_SPD  = 8'(MAX_SPEED);

  function automatic logic [7:0] clamp_speed(input logic [7:0] v);
    if (v < 8'd1)         return 8'd1;
    else if (v > MAX_SPD) return MAX_SPD;
    else                  return v;
  endfunction

  state_t              state;
  logic [SW-1:0]       serve_cnt;
  logic                versus;
  logic [9:0]          y_next;
  logic signed [7:0]   vy_next;
  logic [1:0]          grav_next;

  ball_vertical_phys #(
    .V_RES      (V_RES),
    .BALL_SIZE  (BALL_SIZE),
    .GRAV_PERIOD(GRAV_PERIOD)
  ) u_vphys (
    .y            (ball_y_out),
    .vy           (ball_vy),
    .grav_cnt     (gravity_counter),
    .y_next       (y_next),
    .vy_next      (vy_next),
    .grav_cnt_next(grav_next)
  );

  always_ff @(posedge clk_25MHZ) begin
    if (reset) begin
      state               <= IDLE;
      serve_cnt           <= '0;
      versus              <= 1'b0;
      ball_x_out          <= X_CENTER;
      ball_y_out          <= Y_CENTER;
      is_ball_moving_left <= 1'b1;
      game_over           <= 1'b0;
      ball_send_trigger   <= 1'b0;
      ball_vy             <= '0;
      gravity_counter     <= '0;
      ball_speed          <= INIT_SPD;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (game_start) begin
            state               <= SERVE;
            serve_cnt           <= '0;
            versus              <= mode;
            game_over           <= 1'b0;
            ball_x_out          <= X_CENTER;
            ball_y_out          <= Y_CENTER;
            is_ball_moving_left <= 1'b1;
            ball_vy             <= '0;
            gravity_counter     <= '0;
            ball_speed          <= INIT_SPD;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (serve_cnt == SW'(SERVE_FRAMES - 1)) state <= MOVE;
            else serve_cnt <= serve_cnt + 1'b1;
          end
        end
        MOVE: begin
          if (frame_tick) begin
            ball_y_out      <= y_next;
            ball_vy         <= vy_next;
            gravity_counter <= grav_next;
            // A hit on the miss frame wins: the paddle reached the ball in time.
            if (is_ball_moving_left) begin
              if (collision_detected) begin
                is_ball_moving_left <= 1'b0;
                ball_speed          <= clamp_speed(estimated_speed[9:2]);
              end else if (ball_x_out < {2'b00, ball_speed}) begin
                ball_x_out <= '0;
                game_over  <= 1'b1;
                state      <= OVER;
              end else begin
                ball_x_out <= ball_x_out - {2'b00, ball_speed};
              end
            end else if (11'(ball_x_out) + 11'(ball_speed) >= 11'(X_RIGHT)) begin
              ball_x_out <= X_RIGHT;
              if (versus) begin
                state             <= SEND;
                ball_send_trigger <= 1'b1;
              end else begin
                is_ball_moving_left <= 1'b1;
              end
            end else begin
              ball_x_out <= ball_x_out + {2'b00, ball_speed};
            end
          end
        end
        SEND: begin
          ball_send_trigger <= 1'b0;
          ball_x_out        <= X_OFF;
          state             <= WAIT_RX;
        end
        WAIT_RX: begin
          if (rx_valid) begin
            ball_x_out          <= X_RIGHT;
            ball_y_out          <= (rx_ball_y > Y_MAX) ? Y_MAX : rx_ball_y;
            ball_vy             <= rx_vy;
            ball_speed          <= clamp_speed(rx_speed);
            is_ball_moving_left <= 1'b1;
            state               <= MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
